// File: rtl/iiitb_uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a selectable oversample-tick period.
// Reports good bytes with data_valid, bad stop bits with frame_err, and holds in BREAK while the line stays low.
module iiitb_uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic       rx_p0;
  logic       rxs;
  logic       rxs_d;
  logic [1:0] warm_p;
  logic       armed;
  logic [2:0] state;
  logic [1:0] sel_l;
  logic [2:0] presc;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       tick;
  logic       start_edge;

  // Last prescaler count for each baud select (N-1 for N = 8/4/2/1).
  function automatic logic [2:0] presc_max(input logic [1:0] s);
    logic [2:0] m;
    case (s)
      2'b00:   m = 3'd7;
      2'b01:   m = 3'd3;
      2'b10:   m = 3'd1;
      default: m = 3'd0;
    endcase
    return m;
  endfunction

  assign tick       = (presc == presc_max(sel_l));
  // armed blocks a line that is already low at reset release from looking like a start edge.
  assign start_edge = armed & rxs_d & ~rxs;
  assign busy       = (state != IDLE);

  // Synchronizer stage: rx -> rx_p0 -> rxs, plus edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      warm_p <= 2'b00;
      armed  <= 1'b0;
    end else begin
      rx_p0  <= rx;
      rxs    <= rx_p0;
      rxs_d  <= rxs;
      warm_p <= {warm_p[0], 1'b1};
      if (warm_p[1] && rxs)
        armed <= 1'b1;
    end
  end

  // Framing stage: prescaler, tick counter and receive FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel_l      <= 2'b00;
      presc      <= 3'd0;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || tick)
        presc <= 3'd0;
      else
        presc <= presc + 3'd1;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            sel_l    <= sel;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= 4'd0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt       <= 4'd0;
              shreg[bit_idx] <= rxs;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'd7)
                state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= 4'd0;
              if (rxs) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        BREAK: begin
          if (rxs)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/iiitb_uart_rx.md
IIITB_UART_RX -- requirements
Module: iiitb_uart_rx

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, release is synchronous to clk.
REQ-004 sel  input  2  baud select: 00/01/10/11 give oversample-tick periods N = 8/4/2/1 clk, so bit periods are 128/64/32/16 clk.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 data_out  output  8  last correctly framed byte; held until the next good frame.
REQ-007 data_valid  output  1  one-clk pulse when data_out is updated.
REQ-008 frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-012 Prescaler: counts 0..N-1 and emits a tick when the count equals N-1; cleared on leaving IDLE.
REQ-013 Tick counter: 4 bits; cleared on leaving IDLE and at every bit sample.
REQ-014 IDLE -> START on a falling edge of rxs (previous 1, current 0); sel SHALL be latched at this edge and held for the whole frame.
REQ-015 START: on the 8th tick, if rxs = 0 -> DATA; if rxs = 1 it is a false start -> IDLE with no output pulse.
REQ-016 DATA: on every 16th tick, sample rxs into bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-017 STOP: on the 16th tick, sample rxs.
  - rxs = 1: data_out <= shift register and data_valid = 1 for exactly one clk on the next edge; -> IDLE.
  - rxs = 0: frame_err = 1 for one clk; data_out unchanged; -> BREAK.
REQ-018 BREAK: remain until rxs = 1, then -> IDLE; no further pulses while in BREAK.
REQ-019 data_valid and frame_err SHALL never be high in the same cycle.
REQ-020 A new start edge SHALL be accepted in the first IDLE cycle after STOP, so back-to-back frames are supported.
REQ-021 Changing sel mid-frame SHALL have no effect until the next start edge.
REQ-022 Latency: data_valid rises 1 clk after the stop-bit sample, which is 9.5 bit periods after the start edge plus 2 synchronizer clk.

Reset
REQ-023 While reset = 0: data_out = 8'h00, data_valid = 0, frame_err = 0, busy = 0; FSM = IDLE; prescaler, tick counter, bit index and shift register = 0; latched sel = 00; synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-025 After reset release the block SHALL wait for a fresh falling edge; a line that is already low SHALL NOT be treated as a start.

Verification
REQ-026 sel=00, send 0xA5 with 128-clk bits -> exactly one data_valid pulse, data_out = 8'hA5, frame_err never high, busy low afterwards.
REQ-027 sel=00, rx low for 40 clk then high -> no data_valid, no frame_err, busy returns low after the 8th tick (~64 clk).
REQ-028 sel=01, send 0x3C with stop bit = 0, hold rx low for 500 clk, then high -> one frame_err pulse, data_out keeps its previous value, busy high until rx goes high.
REQ-029 sel=11, back-to-back 0x00 then 0xFF (16-clk bits, no idle gap) -> two data_valid pulses with data_out 8'h00 then 8'hFF.
REQ-030 sel=10, assert reset during bit 3 of a frame, release, then send 0x81 -> outputs zero during reset, no pulse from the aborted frame, next frame gives data_out = 8'h81.
REQ-031 Start 0x5A at sel=00, switch sel to 11 during bit 2 -> 0x5A is still received correctly at the 128-clk rate.
